// File: rtl/noise_pkg.sv
// rtl/noise_pkg.sv - shared constants and state type for the noise mixer
// Contents:
//   WIN_LOG2_DEF : default log2 of the pulse-counting window length
//   DAC_W        : DAC sample width
//   AVG_SHIFT    : running-average step shift
//   state_t      : IDLE / COUNT measurement state
package noise_pkg;

    localparam int WIN_LOG2_DEF = 8;
    localparam int DAC_W        = 8;
    localparam int AVG_SHIFT    = 3;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/pulse_sync.sv
// rtl/pulse_sync.sv - 3-FF synchronizer and rising-edge detector for the noise pulse train
// Ports:
//   clk_200    : system clock
//   rst        : asynchronous active-low reset
//   noise_wave : asynchronous noise pulse train
//   rise       : one-cycle pulse per synchronized rising edge
module pulse_sync (
    input  logic clk_200,
    input  logic rst,
    input  logic noise_wave,
    output logic rise
);

    logic sync_a;
    logic sync_b;
    logic prev;

    always_ff @(posedge clk_200 or negedge rst) begin
        if (!rst) begin
            sync_a <= 1'b0;
            sync_b <= 1'b0;
            prev   <= 1'b0;
        end else begin
            sync_a <= noise_wave;
            sync_b <= sync_a;
            prev   <= sync_b;
        end
    end

    assign rise = sync_b & ~prev;

endmodule

// File: rtl/noise_mixer.sv
// rtl/noise_mixer.sv - windowed noise pulse counter with running average and saturating DAC mixer
// Ports:
//   clk_200    : system clock
//   rst        : asynchronous active-low reset
//   noise_wave : asynchronous noise pulse train
//   enable     : 1 = measure and mix noise, 0 = pass base through
//   amp        : noise gain as a left shift of 0..7
//   base       : unsigned base sample, qualified by base_valid
//   dac_out    : mixed sample, qualified by dac_valid (held between strobes)
//   pulse_cnt  : edge count of the last completed window, qualified by cnt_valid
module noise_mixer
    import noise_pkg::*;
#(
    parameter int WIN_LOG2 = WIN_LOG2_DEF
) (
    input  logic                  clk_200,
    input  logic                  rst,
    input  logic                  noise_wave,
    input  logic                  enable,
    input  logic [2:0]            amp,
    input  logic [DAC_W-1:0]      base,
    input  logic                  base_valid,
    output logic [DAC_W-1:0]      dac_out,
    output logic                  dac_valid,
    output logic [WIN_LOG2:0]     pulse_cnt,
    output logic                  cnt_valid
);

    localparam int CW = WIN_LOG2 + 1;   // edge count / average width
    localparam int OW = WIN_LOG2 + 2;   // signed offset width
    localparam int MW = WIN_LOG2 + 11;  // signed mix width

    state_t                state_q;
    state_t                state_d;
    logic                  rise;
    logic [WIN_LOG2-1:0]   win_cnt;
    logic [CW-1:0]         edge_cnt;
    logic [CW-1:0]         avg;
    logic signed [OW-1:0]  offset;
    logic                  first_done;

    logic                  enter;
    logic                  leave;
    logic                  counting;
    logic                  win_end;
    logic [CW:0]           edge_sum;
    logic [CW-1:0]         count_now;
    logic signed [OW-1:0]  diff;
    logic signed [OW-1:0]  step;
    logic [CW-1:0]         avg_next;
    logic signed [MW-1:0]  base_ext;
    logic signed [MW-1:0]  off_ext;
    logic signed [MW-1:0]  mix;
    logic [DAC_W-1:0]      mix_sat;

    pulse_sync u_pulse_sync (
        .clk_200    (clk_200),
        .rst        (rst),
        .noise_wave (noise_wave),
        .rise       (rise)
    );

    always_ff @(posedge clk_200 or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        enter    = 1'b0;
        leave    = 1'b0;
        counting = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable) begin
                    state_d = COUNT;
                    enter   = 1'b1;
                end
            end
            COUNT: begin
                if (!enable) begin
                    state_d = IDLE;
                    leave   = 1'b1;
                end else begin
                    counting = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Edge on the final window cycle is folded into the ending window's count.
    assign win_end   = counting & (&win_cnt);
    assign edge_sum  = {1'b0, edge_cnt} + {{CW{1'b0}}, rise};
    assign count_now = edge_sum[CW] ? {CW{1'b1}} : edge_sum[CW-1:0];

    assign diff     = $signed({1'b0, count_now}) - $signed({1'b0, avg});
    assign step     = diff >>> AVG_SHIFT;
    // Two's-complement wrap gives avg_old + step truncated to the average width.
    assign avg_next = avg + step[CW-1:0];

    always_ff @(posedge clk_200 or negedge rst) begin
        if (!rst) begin
            win_cnt    <= '0;
            edge_cnt   <= '0;
            pulse_cnt  <= '0;
            cnt_valid  <= 1'b0;
            avg        <= '0;
            offset     <= '0;
            first_done <= 1'b0;
        end else begin
            cnt_valid <= win_end;
            if (enter) begin
                win_cnt  <= '0;
                edge_cnt <= '0;
            end else if (counting) begin
                win_cnt <= win_cnt + WIN_LOG2'(1);
                if (win_end) begin
                    edge_cnt  <= '0;
                    pulse_cnt <= count_now;
                end else begin
                    edge_cnt  <= count_now;
                end
            end

            // Partial window on exit is dropped; avg and pulse_cnt keep their values.
            if (leave) begin
                offset <= '0;
            end else if (win_end) begin
                if (!first_done) begin
                    avg        <= count_now;
                    offset     <= '0;
                    first_done <= 1'b1;
                end else begin
                    avg        <= avg_next;
                    offset     <= diff;
                end
            end
        end
    end

    // Mix uses the registered offset, so a coincident window end still sees the old value.
    assign base_ext = $signed({{(MW-DAC_W){1'b0}}, base});
    assign off_ext  = {{(MW-OW){offset[OW-1]}}, offset};
    assign mix      = base_ext + (off_ext <<< amp);

    always_comb begin
        mix_sat = mix[DAC_W-1:0];
        if (mix[MW-1]) begin
            mix_sat = '0;
        end else if (|mix[MW-2:DAC_W]) begin
            mix_sat = '1;
        end
    end

    always_ff @(posedge clk_200 or negedge rst) begin
        if (!rst) begin
            dac_out   <= '0;
            dac_valid <= 1'b0;
        end else begin
            dac_valid <= base_valid;
            if (base_valid) begin
                dac_out <= mix_sat;
            end
        end
    end

endmodule

// File: tb/tb_noise_mixer.sv
// tb/tb_noise_mixer.sv - directed self-checking bench for noise_mixer
module tb_noise_mixer;

    logic       clk_200 = 1'b0;
    logic       rst = 1'b0;
    logic       noise_wave = 1'b0;
    logic       enable = 1'b0;
    logic [2:0] amp = 3'd0;
    logic [7:0] base = 8'd0;
    logic       base_valid = 1'b0;
    logic [7:0] dac_out;
    logic       dac_valid;
    logic [8:0] pulse_cnt;
    logic       cnt_valid;

    int checks = 0;
    int errors = 0;

    int         strobe_cnt;
    int         strobe_s;
    logic [8:0] strobe_val;
    logic [7:0] dac_a;
    logic       vld_a;
    logic [7:0] dac_b;
    logic       vld_b;
    logic       vld_after_b;

    noise_mixer dut (
        .clk_200    (clk_200),
        .rst        (rst),
        .noise_wave (noise_wave),
        .enable     (enable),
        .amp        (amp),
        .base       (base),
        .base_valid (base_valid),
        .dac_out    (dac_out),
        .dac_valid  (dac_valid),
        .pulse_cnt  (pulse_cnt),
        .cnt_valid  (cnt_valid)
    );

    always #5 clk_200 = ~clk_200;

    task automatic tick();
        @(posedge clk_200);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Runs nslots cycles; npulses square pulses of half-period 'half' from slot 0,
    // plus an optional single-slot pulse at rise_s; optional base_valid at bv_a / bv_b.
    task automatic run_block(input int nslots, input int npulses, input int half,
                             input int rise_s, input int bv_a, input logic [7:0] base_a,
                             input int bv_b, input logic [7:0] base_b);
        strobe_cnt  = 0;
        strobe_s    = -1;
        strobe_val  = 'x;
        dac_a       = 'x;
        vld_a       = 1'bx;
        dac_b       = 'x;
        vld_b       = 1'bx;
        vld_after_b = 1'bx;
        for (int s = 0; s < nslots; s++) begin
            noise_wave = ((s < npulses * 2 * half) && (((s / half) % 2) == 0)) || (s == rise_s);
            base_valid = (s == bv_a) || (s == bv_b);
            base       = (s == bv_a) ? base_a : base_b;
            tick();
            if (cnt_valid === 1'b1) begin
                strobe_cnt++;
                strobe_s   = s;
                strobe_val = pulse_cnt;
            end
            if (s == bv_a) begin
                dac_a = dac_out;
                vld_a = dac_valid;
            end
            if (s == bv_b) begin
                dac_b = dac_out;
                vld_b = dac_valid;
            end
            if (bv_b >= 0 && s == bv_b + 1) vld_after_b = dac_valid;
        end
        noise_wave = 1'b0;
        base_valid = 1'b0;
    endtask

    initial begin
        // Reset with random inputs
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            noise_wave = 1'($urandom);
            enable     = 1'($urandom);
            amp        = 3'($urandom);
            base       = 8'($urandom);
            base_valid = 1'($urandom);
            tick();
            chk("rst_dac_out", dac_out, 0);
            chk("rst_dac_valid", dac_valid, 0);
            chk("rst_pulse_cnt", pulse_cnt, 0);
            chk("rst_cnt_valid", cnt_valid, 0);
        end
        noise_wave = 1'b0;
        enable     = 1'b0;
        base_valid = 1'b0;
        base       = 8'd55;
        rst        = 1'b1;
        for (int i = 0; i < 3; i++) tick();
        chk("post_rst_dac_out", dac_out, 0);
        chk("post_rst_dac_valid", dac_valid, 0);

        // Pass-through
        amp        = 3'd3;
        base       = 8'd100;
        base_valid = 1'b1;
        tick();
        chk("pass_dac_out", dac_out, 100);
        chk("pass_dac_valid", dac_valid, 1);
        base_valid = 1'b0;
        base       = 8'd77;
        tick();
        chk("pass_dac_valid_drop", dac_valid, 0);
        chk("pass_dac_hold", dac_out, 100);

        // Steady rate: 64 edges per 256-cycle window
        amp    = 3'd4;
        enable = 1'b1;
        run_block(256, 64, 2, -1, 100, 8'd10, -1, 8'd0);
        chk("w0_no_strobe", strobe_cnt, 0);
        chk("w0_mix", dac_a, 10);
        chk("w0_mix_valid", vld_a, 1);
        run_block(256, 64, 2, -1, 5, 8'd30, -1, 8'd0);
        chk("w1_strobes", strobe_cnt, 1);
        chk("w1_strobe_pos", strobe_s, 0);
        chk("w1_pulse_cnt", strobe_val, 64);
        chk("w1_first_offset_mix", dac_a, 30);
        run_block(256, 64, 2, -1, 5, 8'd40, -1, 8'd0);
        chk("w2_strobes", strobe_cnt, 1);
        chk("w2_pulse_cnt", strobe_val, 64);
        chk("w2_steady_offset_mix", dac_a, 40);

        // Saturation: 80 edges then 40 edges around avg 64
        run_block(256, 80, 1, -1, -1, 8'd0, -1, 8'd0);
        chk("w3_pulse_cnt", strobe_val, 64);
        run_block(256, 40, 1, -1, 0, 8'd200, 1, 8'd200);
        chk("w4_pulse_cnt", strobe_val, 80);
        chk("coincide_old_offset0", dac_a, 200);
        chk("sat_high", dac_b, 255);
        chk("sat_high_valid", vld_b, 1);
        chk("sat_high_valid_drop", vld_after_b, 0);
        run_block(256, 10, 2, -1, 0, 8'd50, 1, 8'd50);
        chk("w5_pulse_cnt", strobe_val, 40);
        chk("coincide_old_offset16", dac_a, 255);
        chk("sat_low", dac_b, 0);

        // Enable drop at window cycle 100
        run_block(101, 20, 2, -1, -1, 8'd0, -1, 8'd0);
        chk("w6_strobes", strobe_cnt, 1);
        chk("w6_pulse_cnt", strobe_val, 10);
        enable = 1'b0;
        run_block(300, 0, 1, -1, 10, 8'd123, -1, 8'd0);
        chk("drop_no_strobe", strobe_cnt, 0);
        chk("drop_offset_zero", dac_a, 123);
        chk("drop_pulse_cnt_kept", pulse_cnt, 10);

        // Re-enable: next strobe 256 cycles after entry, avg retained (55)
        amp    = 3'd2;
        enable = 1'b1;
        run_block(256, 30, 2, -1, 50, 8'd200, -1, 8'd0);
        chk("re_no_early_strobe", strobe_cnt, 0);
        chk("re_offset_zero", dac_a, 200);
        run_block(256, 0, 1, -1, 0, 8'd100, 1, 8'd255);
        chk("re_strobes", strobe_cnt, 1);
        chk("re_strobe_pos", strobe_s, 0);
        chk("re_pulse_cnt", strobe_val, 30);
        chk("re_coincide_old", dac_a, 100);
        chk("re_offset_mix", dac_b, 155);

        // Boundary: rise on final window cycle vs first cycle of next window
        run_block(256, 0, 1, 254, -1, 8'd0, -1, 8'd0);
        chk("b0_pulse_cnt", strobe_val, 0);
        run_block(256, 0, 1, 255, -1, 8'd0, 1, 8'd200);
        chk("b_last_cycle_counted", strobe_val, 1);
        chk("b_offset_mix", dac_b, 28);
        run_block(256, 0, 1, -1, -1, 8'd0, -1, 8'd0);
        chk("b_first_cycle_not_prev", strobe_val, 0);
        run_block(50, 0, 1, -1, -1, 8'd0, -1, 8'd0);
        chk("b_first_cycle_next", strobe_val, 1);

        // Reset mid-window
        run_block(40, 5, 2, -1, -1, 8'd0, -1, 8'd0);
        rst = 1'b0;
        #1;
        chk("midrst_pulse_cnt", pulse_cnt, 0);
        chk("midrst_dac_out", dac_out, 0);
        run_block(300, 20, 2, -1, 10, 8'd99, -1, 8'd0);
        chk("midrst_no_strobe", strobe_cnt, 0);
        chk("midrst_no_dac_valid", vld_a, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/noise_mixer.md
NOISE_MIXER -- requirements
Module: noise_mixer

Interface
REQ-001 Parameter WIN_LOG2, default 8, log2 of the pulse-counting window length in clk_200 cycles.
REQ-002 clk_200  input  1  system clock, 200 MHz; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-low.
REQ-004 noise_wave  input  1  noise pulse train from the noise generator; asynchronous to clk_200.
REQ-005 enable  input  1  1 = measure and mix noise; 0 = pass base through unchanged.
REQ-006 amp  input  3  noise gain, applied as a left shift of 0..7 bits.
REQ-007 base  input  8  unsigned base waveform sample.
REQ-008 base_valid  input  1  single-cycle strobe qualifying base.
REQ-009 dac_out  output  8  unsigned mixed sample for the DAC.
REQ-010 dac_valid  output  1  single-cycle strobe qualifying dac_out.
REQ-011 pulse_cnt  output  WIN_LOG2+1  rising-edge count of the last completed window.
REQ-012 cnt_valid  output  1  single-cycle strobe on each pulse_cnt update.

Function
REQ-013 noise_wave SHALL pass through a 2-FF synchronizer, then a third FF; edge = sync & ~prev; edge asserts 3 cycles after the input rises.
REQ-014 State machine SHALL have 2 states: IDLE and COUNT.
REQ-015 IDLE->COUNT when enable=1; entry clears the window counter and the edge counter.
REQ-016 In COUNT, the window counter (WIN_LOG2 bits) SHALL increment every cycle; the edge counter SHALL increment on edge and saturate at all-ones.
REQ-017 On the cycle the window counter is all-ones, the next edge SHALL set pulse_cnt <= edge_cnt + edge and cnt_valid <= 1, and clear edge_cnt; the window counter wraps to 0 with no dead cycle.
REQ-018 An edge on the final window cycle SHALL count in the ending window.
REQ-019 Running average avg (WIN_LOG2+1 bits unsigned) is maintained per window.
REQ-020 The first completed window after reset SHALL load avg <= count and set offset <= 0.
REQ-021 After the first window, each window SHALL set offset <= count - avg_old (signed, WIN_LOG2+2 bits), then avg <= avg_old + ((count - avg_old) >>> 3), arithmetic, truncated to width.
REQ-022 COUNT->IDLE when enable=0.
REQ-023 On COUNT->IDLE, the partial window SHALL be discarded: no cnt_valid, offset <= 0, avg and pulse_cnt retained.
REQ-024 On base_valid, the next cycle SHALL give dac_out <= sat(base + (offset <<< amp)) and dac_valid = 1 for one cycle; latency is 1.
REQ-025 Mix arithmetic SHALL be signed, at least WIN_LOG2+11 bits wide, with saturation: result <0 -> 0, >255 -> 255.
REQ-026 When base_valid and a window end coincide, the mix SHALL use the offset held before the update.
REQ-027 When enable=0, offset is 0, so dac_out = base.
REQ-028 dac_out SHALL hold its value between strobes.

Reset
REQ-029 While rst=0, the block SHALL be in IDLE with all of these at 0: synchronizer FFs, counters, avg, offset, first-window flag, dac_out, dac_valid, pulse_cnt, cnt_valid.
REQ-030 Reset asserted mid-window SHALL abort the window immediately, with no strobes emitted.

Structure
REQ-031 Shared package noise_pkg SHALL hold the WIN_LOG2 default, the DAC width constant (8), the avg shift constant (3), and the state enum {IDLE, COUNT}.
REQ-032 Sub-module pulse_sync SHALL contain the 3-FF synchronizer and rising-edge detector.
REQ-033 All other logic SHALL reside in noise_mixer.

Verification
REQ-034 Reset test: rst=0 with random inputs -> all outputs 0; release rst -> dac_out stays 0 until the first base_valid.
REQ-035 Pass-through test: enable=0, amp=3, base=100, base_valid pulse -> dac_out=100, dac_valid high exactly 1 cycle later.
REQ-036 Steady-rate test: enable=1, noise_wave period 4 cycles (2 high/2 low), WIN_LOG2=8 -> pulse_cnt=64 with cnt_valid every 256 cycles; first window offset 0; steady offset 0.
REQ-037 Saturation test: avg settled at 64, amp=4.
- Window of 80 edges, base=200 -> offset +16, dac_out=255.
- Then window of 40 edges (avg now 66), base=50 -> offset -26, dac_out=0.
REQ-038 Enable-drop test: enable drops at window cycle 100 -> no cnt_valid, offset 0; re-enable -> next cnt_valid exactly 256 cycles after re-entry to COUNT.
REQ-039 Boundary-edge test: single edge on the window's final cycle -> counted in that window's pulse_cnt, not the next; base_valid coincident with window end -> mix uses old offset.
